// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, single-entry valid/ready byte port.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err; default is 8N1.
module uart_rx #(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int DIV = (clk_freq + 8 * uart_baud_rate) / (16 * uart_baud_rate);
   localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
   } state_t;
`endif

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      sc_q, sc_d;
   logic [2:0]      bc_q, bc_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_q, par_bad_d;
`endif
   logic            rxs;
   logic            tick;
   logic            mid;
   logic            deliver;
   logic            load;

   always_comb begin
      sync1_d      = uart_rxd;
      sync2_d      = sync1_q;
      rxs          = sync2_q;
      tick         = (div_q == DW'(DIV - 1));
      div_d        = tick ? '0 : div_q + DW'(1);
      sc_d         = tick ? sc_q + 4'd1 : sc_q;
      mid          = tick && (sc_q == 4'd15);
      state_d      = state_q;
      bc_d         = bc_q;
      shift_d      = shift_q;
      deliver      = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               // restart the divider so ticks are phased to the start edge
               state_d = S_START;
               div_d   = '0;
               sc_d    = '0;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end
         S_START: begin
            if (tick && (sc_q == 4'd7)) begin
               if (!rxs) begin
                  state_d = S_DATA;
                  sc_d    = '0;
                  bc_d    = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (mid) begin
               shift_d = {rxs, shift_q[7:1]};
               if (bc_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bc_d = bc_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid) begin
               par_bad_d = (rxs != ^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (mid) begin
               if (rxs) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxs) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      load         = deliver && (!rx_valid_q || rx_ready);
      rx_data_d    = load ? shift_q : rx_data_q;
      rx_valid_d   = load || (rx_valid_q && !rx_ready);
      overrun_d    = deliver && !load;
`ifdef UART_RX_PARITY_EN
      parity_err_d = load && par_bad_q;
`else
      parity_err_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         div_q        <= '0;
         sc_q         <= '0;
         bc_q         <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         div_q        <= div_d;
         sc_q         <= sc_d;
         bc_q         <= bc_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
`endif
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random frames against a frame-level receiver model.
// Honours UART_RX_PARITY_EN to drive 8E1 frames and parity cases.
module tb_uart_rx;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int DIV      = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
   localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // sync + detect, then start edge to mid stop bit
   localparam int LAT = 3 + ((2 * (9 + PBITS) + 1) * BIT) / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   uart_rx #(
      .clk_freq       (CLK_FREQ),
      .uart_baud_rate (BAUD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rxd   (uart_rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;
   int clash_cnt = 0;
   int wide_cnt = 0;
   logic fe_p = 1'b0;
   logic ov_p = 1'b0;
   logic pe_p = 1'b0;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      fe_cnt <= fe_cnt + (frame_err === 1'b1 ? 1 : 0);
      ov_cnt <= ov_cnt + (overrun === 1'b1 ? 1 : 0);
      pe_cnt <= pe_cnt + (parity_err === 1'b1 ? 1 : 0);
      clash_cnt <= clash_cnt +
         ((int'(frame_err) + int'(overrun) + int'(parity_err)) > 1 ? 1 : 0);
      wide_cnt <= wide_cnt +
         (((frame_err && fe_p) || (overrun && ov_p) || (parity_err && pe_p)) ? 1 : 0);
      fe_p <= frame_err;
      ov_p <= overrun;
      pe_p <= parity_err;
   end

   // frame-level model: holding register plus expected event counts
   logic [7:0] exp_q[$];
   int exp_fe = 0;
   int exp_ov = 0;
   int exp_pe = 0;
   logic       hold_v = 1'b0;
   logic [7:0] hold_d = 8'h00;

   int         lat_n = 0;
   logic [7:0] lat_d = 8'h00;
   logic [7:0] rb;
   bit         rp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_bits(input int n);
      repeat (n * BIT) @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      uart_rxd = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         wait_bits(1);
      end
`ifdef UART_RX_PARITY_EN
      uart_rxd = (^b) ^ ~par_ok;
      wait_bits(1);
`endif
      uart_rxd = stop_ok;
      wait_bits(1);
      uart_rxd = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      if (!stop_ok) begin
         exp_fe++;
      end else if (hold_v && !rx_ready) begin
         exp_ov++;
      end else begin
         hold_v = 1'b1;
         hold_d = b;
         if (PBITS == 1 && !par_ok) exp_pe++;
      end
   endtask

   task automatic model_consume();
      if (rx_ready && hold_v) begin
         exp_q.push_back(hold_d);
         hold_v = 1'b0;
      end
   endtask

   task automatic send_model(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      send_frame(b, stop_ok, par_ok);
      model_frame(b, stop_ok, par_ok);
      model_consume();
   endtask

   task automatic verify(input string tag);
      int n;
      chk({tag, " bytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, " data"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
      chk({tag, " frame_err"}, 32'(fe_cnt), 32'(exp_fe));
      chk({tag, " overrun"}, 32'(ov_cnt), 32'(exp_ov));
      chk({tag, " parity_err"}, 32'(pe_cnt), 32'(exp_pe));
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) @(posedge clk);
      #2;
      chk("reset rx_data", 32'(rx_data), 32'h0);
      chk("reset rx_valid", 32'(rx_valid), 32'h0);
      chk("reset errs", 32'({frame_err, overrun, parity_err}), 32'h0);
      rst = 1'b1;
      wait_bits(1);

      fork
         send_frame(8'hA5, 1'b1, 1'b1);
         begin
            bit seen = 1'b0;
            while (!seen && lat_n < LAT + 100) begin
               @(posedge clk);
               lat_n++;
               #1;
               if (rx_valid) begin
                  seen  = 1'b1;
                  lat_d = rx_data;
               end
            end
         end
      join
      model_frame(8'hA5, 1'b1, 1'b1);
      model_consume();
      chk("latency", 32'(lat_n), 32'(LAT));
      chk("latency data", 32'(lat_d), 32'hA5);
      verify("a5");

      uart_rxd = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      uart_rxd = 1'b1;
      wait_bits(2);
      verify("glitch");
      send_model(8'h3C, 1'b1, 1'b1);
      verify("3c");

      send_model(8'h55, 1'b0, 1'b1);
      uart_rxd = 1'b0;
      wait_bits(20);
      uart_rxd = 1'b1;
      wait_bits(1);
      verify("break");
      send_model(8'h0F, 1'b1, 1'b1);
      verify("0f");

      rx_ready = 1'b0;
      send_model(8'h11, 1'b1, 1'b1);
      send_model(8'h22, 1'b1, 1'b1);
      chk("held valid", 32'(rx_valid), 32'h1);
      chk("held data", 32'(rx_data), 32'h11);
      rx_ready = 1'b1;
      model_consume();
      @(posedge clk);
      #2;
      rx_ready = 1'b0;
      chk("drained valid", 32'(rx_valid), 32'h0);
      rx_ready = 1'b1;
      verify("overrun");

      uart_rxd = 1'b0;
      wait_bits(1);
      uart_rxd = 1'b1;
      wait_bits(1);
      uart_rxd = 1'b0;
      wait_bits(2);
      rst = 1'b0;
      uart_rxd = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      chk("midreset valid", 32'(rx_valid), 32'h0);
      rst = 1'b1;
      wait_bits(1);
      send_model(8'h7E, 1'b1, 1'b1);
      verify("midreset");

`ifdef UART_RX_PARITY_EN
      send_model(8'h03, 1'b1, 1'b1);
      send_model(8'h07, 1'b1, 1'b0);
      verify("parity");
`endif

      repeat (3) begin
         rb = 8'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
         rp = 1'($urandom_range(0, 1));
`else
         rp = 1'b1;
`endif
         send_model(rb, 1'b1, rp);
      end
      wait_bits(1);
      verify("random");

      chk("pulse clash", 32'(clash_cnt), 32'h0);
      chk("pulse width", 32'(wide_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
